// File: rtl/pwm_pkg.sv
// Shared widths, FSM state type and duty saturation helper for the PWM capture block.
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DUTY_W        = 8;
  localparam int QUO_W         = 9;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } meas_state_t;

  // A full-scale quotient of 256 means the input never went low, so it pins to 0xFF.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [QUO_W-1:0] q);
    return q[QUO_W-1] ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: pin and clear inputs, result outputs.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic              pwm_in;
  logic              ovr_clr;
  logic              valid;
  logic [CNT_W-1:0]  period_out;
  logic [CNT_W-1:0]  high_out;
  logic [DUTY_W-1:0] duty_out;
  logic              static_out;
  logic              overrun;

  modport slave (
    input  pwm_in, ovr_clr,
    output valid, period_out, high_out, duty_out, static_out, overrun
  );

  modport master (
    output pwm_in, ovr_clr,
    input  valid, period_out, high_out, duty_out, static_out, overrun
  );

endinterface

// File: rtl/pwm_divider.sv
// Serial restoring divider: QUO_W-bit floor(dividend*2^(QUO_W-1)/divisor), 1 load + QUO_W iterations.
module pwm_divider
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  logic [CNT_W:0]   rem;
  logic [CNT_W-1:0] div_r;
  logic [QUO_W-2:0] quo;
  logic [3:0]       iter;
  logic             busy_q;
  logic             ge;
  logic [CNT_W-1:0] diff;
  logic             last;

  // The remainder never exceeds the divisor after a subtract, so CNT_W bits hold the difference.
  always_comb begin
    ge   = (rem >= {1'b0, div_r});
    diff = ge ? (rem[CNT_W-1:0] - div_r) : rem[CNT_W-1:0];
    last = busy_q && (iter == 4'(QUO_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      div_r  <= '0;
      quo    <= '0;
      iter   <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem    <= {1'b0, dividend};
      div_r  <= divisor;
      quo    <= '0;
      iter   <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem  <= {diff, 1'b0};
      quo  <= {quo[QUO_W-3:0], ge};
      iter <= iter + 4'd1;
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = last;
  assign quotient = {quo, ge};

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time / duty capture with timeout and overrun reporting.
//   state   | meaning
//   UNARMED | waiting for a first rising edge; counts saturate, no results
//   ARMED   | counting since last rising edge; next edge captures, saturation times out
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   rise_det;

  meas_state_t      state, state_d;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] cap_period, cap_high;
  logic             cnt_max;
  logic             cnt_load, div_start, ovr_evt, to_evt;

  logic             div_busy, div_done;
  logic [QUO_W-1:0] div_quo;

  logic              to_pend, to_lvl;
  logic              valid_q, static_q, overrun_q;
  logic [CNT_W-1:0]  period_q, high_q;
  logic [DUTY_W-1:0] duty_q;

  // lvl_q is the synchronized level aligned with rise_det, so high counting starts on the edge cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      lvl_q    <= 1'b0;
      rise_det <= 1'b0;
    end else begin
      sync_q   <= (sync_q << 1) | SYNC_STAGES'(bus.pwm_in);
      lvl_q    <= sync_q[SYNC_STAGES-1];
      rise_det <= sync_q[SYNC_STAGES-1] & ~lvl_q;
    end
  end

  assign cnt_max = (per_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNARMED;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      UNARMED: if (rise_det) state_d = ARMED;
      ARMED:   if (!rise_det && cnt_max) state_d = UNARMED;
      default: state_d = UNARMED;
    endcase
  end

  always_comb begin
    cnt_load  = 1'b0;
    div_start = 1'b0;
    ovr_evt   = 1'b0;
    to_evt    = 1'b0;
    case (state)
      UNARMED: cnt_load = rise_det;
      ARMED: begin
        cnt_load  = rise_det;
        div_start = rise_det && !div_busy;
        ovr_evt   = rise_det && div_busy;
        to_evt    = !rise_det && cnt_max;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_load) begin
      per_cnt <= CNT_ONE;
      hi_cnt  <= CNT_ONE;
    end else begin
      if (!cnt_max) per_cnt <= per_cnt + CNT_ONE;
      if (lvl_q && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_period <= '0;
      cap_high   <= '0;
    end else if (div_start) begin
      cap_period <= per_cnt;
      cap_high   <= hi_cnt;
    end
  end

  pwm_divider #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (hi_cnt),
    .divisor  (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // A timeout result waits one cycle if a division completes at the same time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_pend <= 1'b0;
      to_lvl  <= 1'b0;
    end else if (to_evt) begin
      to_pend <= 1'b1;
      to_lvl  <= lvl_q;
    end else if (to_pend && !div_done) begin
      to_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      static_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (div_done) begin
        valid_q  <= 1'b1;
        period_q <= cap_period;
        high_q   <= cap_high;
        duty_q   <= sat_duty(div_quo);
        static_q <= 1'b0;
      end else if (to_pend) begin
        valid_q  <= 1'b1;
        period_q <= CNT_MAX;
        high_q   <= to_lvl ? CNT_MAX : '0;
        duty_q   <= to_lvl ? {DUTY_W{1'b1}} : '0;
        static_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun_q <= 1'b0;
    else if (ovr_evt) overrun_q <= 1'b1;
    else if (bus.ovr_clr) overrun_q <= 1'b0;
  end

  assign bus.valid      = valid_q;
  assign bus.period_out = period_q;
  assign bus.high_out   = high_q;
  assign bus.duty_out   = duty_q;
  assign bus.static_out = static_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, SHALL be the width of the period and high-time counters in clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be the number of input synchronizer flops on pwm_in.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst, asynchronous and active-high.
REQ-004 Port clk, input, 1: sole clock, all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port pwm_in, input, 1: asynchronous PWM waveform under measurement.
REQ-007 Port ovr_clr, input, 1: synchronous clear of the overrun flag.
REQ-008 Port valid, output, 1: one-cycle pulse when period_out, high_out, duty_out and static_out update.
REQ-009 Port period_out, output, CNT_W: last measured period, in clk cycles.
REQ-010 Port high_out, output, CNT_W: last measured high time, in clk cycles.
REQ-011 Port duty_out, output, 8: last duty code, same scale as the PWM generator (0x00 = 0 %, 0xFF = 100 %).
REQ-012 Port static_out, output, 1: last result came from a timeout, not from a measured edge pair.
REQ-013 Port overrun, output, 1: sticky; an edge arrived while a division was in progress.

Function
REQ-014 pwm_in SHALL pass through SYNC_STAGES flops; a rising edge SHALL be detected one cycle later (rise_det).
REQ-015 Measurement FSM SHALL have states UNARMED and ARMED; reset state SHALL be UNARMED.
REQ-016 In UNARMED, rise_det SHALL load period count 1 and high count 1, go to ARMED, and produce no valid.
REQ-017 In ARMED, the period count SHALL increment every cycle; the high count SHALL increment on every cycle the synchronized level is 1.
REQ-018 In ARMED, on rise_det the block SHALL capture period = period count and high = high count, reload both counts to 1, and start the divider.
REQ-019 Duty SHALL be floor(high*256/period), computed by a serial restoring division with a 9-bit quotient; a quotient >= 256 SHALL saturate to 0xFF.
REQ-020 The divider SHALL take exactly 10 cycles from start (1 load + 9 iterations); valid SHALL assert in the cycle after the last iteration, with all outputs updated in the same cycle and static_out = 0.
REQ-021 Timeout: if the period count reaches 2^CNT_W-1 in ARMED, the block SHALL go to UNARMED and emit valid once with period_out = all ones, static_out = 1, and high_out/duty_out = all ones/0xFF if the synchronized level is 1, else 0/0x00.
REQ-022 In UNARMED, counts SHALL saturate at 2^CNT_W-1 and no further timeout valid SHALL be emitted until a new rise_det re-arms the block.
REQ-023 rise_det while the divider is busy SHALL still reload the counts but SHALL discard that capture and set overrun; the running division SHALL complete normally.
REQ-024 overrun SHALL clear on ovr_clr = 1 unless a new overrun event occurs in the same cycle (set wins).
REQ-025 A timeout coinciding with a divider completion SHALL emit the divider result first; the timeout result SHALL follow on the next cycle.
REQ-026 Outputs SHALL hold their last values between valid pulses.

Reset
REQ-027 On rst, all outputs SHALL be 0, the FSM SHALL be UNARMED, the divider SHALL be idle, and the synchronizer flops SHALL be 0.
REQ-028 rst asserted mid-division SHALL abort the division; no valid SHALL be emitted after reset release until a new edge pair has been measured.

Structure
REQ-029 Package pwm_pkg SHALL hold CNT_W default, DUTY_W = 8, the quotient width (9), and the measurement FSM state typedef.
REQ-030 The serial divider SHALL be a separate sub-module, pwm_divider, with start/busy/done handshake; remaining logic stays in pwm_capture.

Verification
REQ-031 Period 3328, high 1664 cycles, repeated -> each valid after the first edge pair gives period_out = 3328, high_out = 1664, duty_out = 0x80, static_out = 0.
REQ-032 Period 3328, high 3315 -> duty_out = 0xFF; period 3328, high 13 -> duty_out = 0x01.
REQ-033 pwm_in held at 1 for 70000 cycles after one rising edge -> exactly one valid with period_out = 0xFFFF, high_out = 0xFFFF, duty_out = 0xFF, static_out = 1; held at 0 -> duty_out = 0x00, high_out = 0.
REQ-034 Period 6 cycles -> overrun = 1; a pulse on ovr_clr clears it; the results that do complete stay correct.
REQ-035 rst asserted 4 cycles into a division -> all outputs are 0; no valid until two further rising edges, then a correct result.
REQ-036 Rising edge at pin -> rise_det 3 cycles later, and valid exactly 10 cycles after rise_det.
